bank_ctrl: RTL

- Per-bank controller sitting directly downstream of the crossbar; one instance per bank (4 total).
- Accepts one bank request per cycle from the crossbar bank port and drives a single-port SRAM with 1-cycle read latency.
- Every accepted request returns exactly one response (read data, or write ack carrying wbuffer_id), tagged with the originating channel one-hot id, through a credit-protected response FIFO.
- The crossbar response path routes responses using that tag.

---
 rtl/bank_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bank_ctrl.sv
// Per-bank SRAM controller: one request per cycle in, one tagged response per accepted request out.
// Latency 2 cycles fire-to-rsp_valid; req_ready is withheld by credits so the response FIFO never overflows.

// Generic synchronous FIFO with extra-MSB pointers.
// Head visible combinationally; pushes while full are dropped, pops while empty are ignored.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_rdy & ~empty;
  assign count   = wr_ptr - rd_ptr;
  assign pop_vld = ~empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Bank controller: drives a 1-cycle-latency single-port SRAM and queues tagged responses.
// Fire at N gives rsp_valid at N+2 earliest; req_ready drops once queued plus in-flight reach RSP_DEPTH.
module bank_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int CH_NUM    = 3,
  parameter int WBID_W    = 5,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [CH_NUM-1:0] req_channel_1hot_id,
  input  logic [WBID_W-1:0] req_wbuffer_id,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [CH_NUM-1:0] rsp_channel_1hot_id,
  output logic [WBID_W-1:0] rsp_wbuffer_id,
  output logic              err_onehot
);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] rdata;
    logic [CH_NUM-1:0] ch;
    logic [WBID_W-1:0] wbid;
  } rsp_ent_t;

  logic              fire;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credits_used;

  logic              inflight_vld;
  logic              inflight_op;
  logic [CH_NUM-1:0] inflight_ch;
  logic [WBID_W-1:0] inflight_wbid;

  rsp_ent_t          push_ent;
  rsp_ent_t          head_ent;
  rsp_ent_t          out_ent;
  logic              head_vld;

  // Credits count only registered state: a pop this cycle frees its slot next cycle.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_vld};
  assign req_ready    = ~rst & (credits_used < (CNT_W+1)'(RSP_DEPTH));
  assign fire         = req_valid & req_ready;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (fire) begin
      sram_ce    = 1'b1;
      sram_we    = req_op;
      sram_addr  = req_addr;
      sram_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_vld  <= 1'b0;
      inflight_op   <= 1'b0;
      inflight_ch   <= '0;
      inflight_wbid <= '0;
    end else begin
      inflight_vld <= fire;
      if (fire) begin
        inflight_op   <= req_op;
        inflight_ch   <= req_channel_1hot_id;
        inflight_wbid <= req_wbuffer_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_onehot <= 1'b0;
    end else if (fire && ($countones(req_channel_1hot_id) != 1)) begin
      err_onehot <= 1'b1;
    end
  end

  // SRAM read data lands the cycle after fire, alongside the in-flight tag.
  always_comb begin
    push_ent.op    = inflight_op;
    push_ent.rdata = inflight_op ? '0 : sram_rdata;
    push_ent.ch    = inflight_ch;
    push_ent.wbid  = inflight_wbid;
  end

  fifo #(
    .WIDTH ($bits(rsp_ent_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_vld),
    .push_dat (push_ent),
    .pop_vld  (head_vld),
    .pop_rdy  (rsp_ready),
    .pop_dat  (head_ent),
    .count    (fifo_count)
  );

  // Zero the outputs while empty so a flushed or stale entry never shows.
  assign rsp_valid           = head_vld;
  assign out_ent             = head_vld ? head_ent : '0;
  assign rsp_op              = out_ent.op;
  assign rsp_rdata           = out_ent.rdata;
  assign rsp_channel_1hot_id = out_ent.ch;
  assign rsp_wbuffer_id      = out_ent.wbid;
endmodule
